// File: rtl/pwm11_duty_meas.sv
// PWM duty/period meter: synchronizes PWM_sig, counts clocks per rising-to-rising
// period and clocks spent high, and reports the last complete period. If no
// rising edge arrives within TIMEOUT clocks, it reports a stuck input once and
// then waits silently for the waveform to resume.
module pwm11_duty_meas #(
  parameter logic [11:0] TIMEOUT = 12'd3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PWM_sig,
  output logic [10:0] duty,
  output logic [11:0] period,
  output logic        vld,
  output logic        stuck
);

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    STUCK
  } state_t;

  state_t      state, state_nxt;
  logic        sync1, synced, prev;
  logic        rise;
  logic [11:0] per_cnt, high_cnt;
  logic        meas_upd, stuck_upd;

  assign rise = synced & ~prev;

  // Two-flop synchronizer plus a history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync1  <= PWM_sig;
      synced <= sync1;
      prev   <= synced;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and update strobes; a rise always wins over the timeout
  always_comb begin
    state_nxt = state;
    meas_upd  = 1'b0;
    stuck_upd = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEAS;
        end else if (per_cnt == TIMEOUT) begin
          state_nxt = STUCK;
          stuck_upd = 1'b1;
        end
      end
      MEAS: begin
        if (rise) begin
          meas_upd = 1'b1;
        end else if (per_cnt == TIMEOUT) begin
          state_nxt = STUCK;
          stuck_upd = 1'b1;
        end
      end
      STUCK: begin
        if (rise) state_nxt = MEAS;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Period and high-time counters; frozen once the input is declared stuck
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt  <= '0;
      high_cnt <= '0;
    end else if (rise) begin
      per_cnt  <= 12'd1;
      high_cnt <= 12'd1;
    end else if (state != STUCK && !stuck_upd) begin
      per_cnt  <= per_cnt + 12'd1;
      high_cnt <= high_cnt + {11'd0, synced};
    end
  end

  // Result registers, written only together with the vld strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty   <= '0;
      period <= '0;
      stuck  <= 1'b0;
      vld    <= 1'b0;
    end else begin
      vld <= meas_upd | stuck_upd;
      if (meas_upd) begin
        duty   <= high_cnt[11] ? 11'h7FF : high_cnt[10:0];
        period <= per_cnt;
        stuck  <= 1'b0;
      end else if (stuck_upd) begin
        duty   <= synced ? 11'h7FF : 11'h000;
        period <= 12'hFFF;
        stuck  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm11_duty_meas.sv
// Scoreboard bench for pwm11_duty_meas: the driver records the waveform per clock
// and predicts each report from rise times and high-level sums; the monitor
// checks every vld against the predicted cycle and values.
module tb_pwm11_duty_meas;

  localparam int unsigned TMO = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm = 1'b0;
  logic [10:0] duty;
  logic [11:0] period;
  logic        vld;
  logic        stuck;

  pwm11_duty_meas #(.TIMEOUT(12'd3000)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .PWM_sig(pwm),
    .duty   (duty),
    .period (period),
    .vld    (vld),
    .stuck  (stuck)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned t;
    logic [10:0] d;
    logic [11:0] p;
    logic        s;
  } exp_t;

  exp_t q[$];
  bit   lv[int unsigned];

  // reference model state: anchor time, whether a timeout is still pending,
  // whether the anchor is a real rise that opens a measurable period
  int unsigned anchor;
  bit          armed;
  bit          measuring;
  bit          done = 1'b0;
  bit          final_done = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic model_step(input int unsigned e, input logic v);
    int unsigned hs;
    exp_t x;
    lv[e] = v;
    if (v && !lv[e-1]) begin
      if (measuring) begin
        hs = 0;
        for (int unsigned i = anchor; i < e; i++) hs += lv[i];
        x.t = e + 3;
        x.d = (hs > 2047) ? 11'h7FF : hs[10:0];
        x.p = 12'(e - anchor);
        x.s = 1'b0;
        q.push_back(x);
      end
      anchor    = e;
      measuring = 1'b1;
      armed     = 1'b1;
    end else if (armed && (e - anchor == TMO)) begin
      x.t = e + 3;
      x.d = v ? 11'h7FF : 11'h000;
      x.p = 12'hFFF;
      x.s = 1'b1;
      q.push_back(x);
      armed     = 1'b0;
      measuring = 1'b0;
    end
  endtask

  task automatic tick(input logic v);
    pwm = v;
    if (rst_n) model_step(cyc, v);
    else lv[cyc] = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int unsigned h, input int unsigned p);
    for (int unsigned i = 0; i < p; i++) tick(i < h);
  endtask

  task automatic release_rst();
    rst_n     = 1'b1;
    anchor    = cyc - 2;
    lv[cyc-2] = 1'b0;
    lv[cyc-1] = 1'b0;
    armed     = 1'b1;
    measuring = 1'b0;
  endtask

  task automatic reset_pulse(input int unsigned n);
    rst_n = 1'b0;
    for (int unsigned i = 0; i < n; i++) tick(1'b0);
    release_rst();
  endtask

  task automatic chk(input bit ok, input string name, input int unsigned act,
                     input int unsigned req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: reset values, vld timing/content, and output hold between reports
  logic [10:0] cur_d = '0;
  logic [11:0] cur_p = '0;
  logic        cur_s = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      cur_d = '0;
      cur_p = '0;
      cur_s = 1'b0;
      chk(vld == 1'b0, "reset_vld", vld, 0);
      chk(duty == 11'h000, "reset_duty", duty, 0);
      chk(period == 12'h000, "reset_period", period, 0);
      chk(stuck == 1'b0, "reset_stuck", stuck, 0);
    end else begin
      while (q.size() > 0 && q[0].t < cyc) begin
        chk(1'b0, "missing_vld", cyc, q[0].t);
        void'(q.pop_front());
      end
      if (vld) begin
        if (q.size() == 0 || q[0].t != cyc) begin
          chk(1'b0, "unexpected_vld", cyc, (q.size() > 0) ? q[0].t : 0);
        end else begin
          e = q.pop_front();
          chk(duty == e.d, "vld_duty", duty, e.d);
          chk(period == e.p, "vld_period", period, e.p);
          chk(stuck == e.s, "vld_stuck", stuck, e.s);
          cur_d = e.d;
          cur_p = e.p;
          cur_s = e.s;
        end
      end else begin
        chk(duty == cur_d, "hold_duty", duty, cur_d);
        chk(period == cur_p, "hold_period", period, cur_p);
        chk(stuck == cur_s, "hold_stuck", stuck, cur_s);
      end
      if (done && !final_done) begin
        chk(q.size() == 0, "pending_reports", q.size(), 0);
        final_done = 1'b1;
      end
    end
  end

  initial begin
    int unsigned h, p;
    for (int i = 0; i < 4; i++) tick(1'b0);
    release_rst();

    // no edge at all after reset: timeout from IDLE with input low
    for (int i = 0; i < 3100; i++) tick(1'b0);

    // steady 50% waveform, then a step 0x123 -> 0x7FF, then the extremes
    for (int i = 0; i < 4; i++) pulses(11'h400, 2048);
    pulses(11'h123, 2048);
    pulses(11'h7FF, 2048);
    pulses(1, 2048);
    pulses(11'h7FF, 2048);

    // random duty at nominal period, then random period and duty
    for (int i = 0; i < 4; i++) begin
      h = $urandom_range(2047, 1);
      pulses(h, 2048);
    end
    for (int i = 0; i < 4; i++) begin
      p = $urandom_range(2600, 1500);
      h = $urandom_range(p - 1, 1);
      pulses(h, p);
    end

    // saturating high time
    pulses(2100, 2200);
    pulses(11'h300, 2048);

    // stuck low, then resume
    for (int i = 0; i < 3100; i++) tick(1'b0);
    pulses(11'h200, 2048);
    pulses(11'h200, 2048);

    // stuck high, then resume
    for (int i = 0; i < 3100; i++) tick(1'b1);
    for (int i = 0; i < 100; i++) tick(1'b0);
    pulses(11'h200, 2048);
    pulses(11'h200, 2048);

    // rise exactly at the timeout wins; one clock later it does not
    pulses(10, 2048);
    pulses(10, 3000);
    pulses(10, 3001);
    pulses(10, 2048);
    pulses(10, 2048);

    // reset in the middle of a period
    pulses(11'h300, 2048);
    pulses(11'h300, 1000);
    reset_pulse(5);
    pulses(11'h300, 2048);
    pulses(11'h300, 2048);
    pulses(11'h300, 2048);

    for (int i = 0; i < 20; i++) tick(1'b0);
    done = 1'b1;
    for (int i = 0; i < 5 && !final_done; i++) @(posedge clk);
    if (!final_done) begin
      errors++;
      $display("FAIL final_check: got 0, expected 1");
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
